// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states and the
// operation-select encoding used by the start decoder.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_e;

  typedef enum logic [1:0] {
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } op_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on operand magnitudes.
// Multiply: {hi,lo} = ({hi + (lo[0] ? opnd : 0), lo}) >> 1, multiplier in lo.
// Divide (only with MULDIV_DIV_EN): restoring shift-subtract, remainder in
// hi, dividend shifting out of / quotient shifting into lo.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             is_div_i,
`endif
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] shifted;
  logic           ge;
`endif

  // Combinational single-step datapath
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    shifted = {hi_i, lo_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd_i});
    if (is_div_i) begin
      // When ge holds, shifted - opnd < opnd, so the low WIDTH bits suffice.
      hi_o = ge ? (shifted[WIDTH-1:0] - opnd_i) : shifted[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Optional divide path is built only when MULDIV_DIV_EN is defined;
// otherwise op_div/op_divu are ignored and div_zero is tied low.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_mult,
  input  logic             op_multu,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             op_mthi,
  input  logic             op_mtlo,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     acc_hi_q, acc_lo_q, opnd_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 neg_a_q, neg_b_q;
  logic                 done_q;
`ifdef MULDIV_DIV_EN
  logic                 is_div_q, divz_q, dz_q;
`else
  logic                 unused_div_ops;
  assign unused_div_ops = op_div | op_divu;
`endif

  logic                 start;
  op_e                  op_sel;
  logic                 sgn, neg_a, neg_b;
  logic [WIDTH-1:0]     a_mag, b_mag, load_lo, load_opnd;
  logic [WIDTH-1:0]     step_hi, step_lo;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  // Start decode with mult > multu > div > divu priority
  always_comb begin
    start  = 1'b0;
    op_sel = OP_MULT;
    if (op_mult) begin
      start  = 1'b1;
      op_sel = OP_MULT;
    end else if (op_multu) begin
      start  = 1'b1;
      op_sel = OP_MULTU;
    end
`ifdef MULDIV_DIV_EN
    else if (op_div) begin
      start  = 1'b1;
      op_sel = OP_DIV;
    end else if (op_divu) begin
      start  = 1'b1;
      op_sel = OP_DIVU;
    end
`endif
  end

  // Operand magnitudes and initial accumulator load for the accepted op
  always_comb begin
    sgn       = op_is_signed(op_sel);
    neg_a     = sgn & alu_a[WIDTH-1];
    neg_b     = sgn & alu_b[WIDTH-1];
    a_mag     = neg_a ? -alu_a : alu_a;
    b_mag     = neg_b ? -alu_b : alu_b;
    load_lo   = b_mag;
    load_opnd = a_mag;
`ifdef MULDIV_DIV_EN
    if (op_is_div(op_sel)) begin
      load_lo   = a_mag;
      load_opnd = b_mag;
    end
`endif
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div_i (is_div_q),
`endif
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Sign correction of the finished magnitudes
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      // Zero divisor leaves |a| as remainder; the dividend-sign fix then
      // restores the raw dividend, so only the quotient needs forcing.
      fix_hi = neg_a_q ? -acc_hi_q : acc_hi_q;
      fix_lo = divz_q ? '1 : ((neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q);
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: if (cnt_q == LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
`ifdef MULDIV_DIV_EN
    div_zero = dz_q;
`else
    div_zero = 1'b0;
`endif
  end

  // Datapath registers, HI/LO and result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      divz_q   <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      dz_q   <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= load_lo;
            opnd_q   <= load_opnd;
            neg_a_q  <= neg_a;
            neg_b_q  <= neg_b;
`ifdef MULDIV_DIV_EN
            is_div_q <= op_is_div(op_sel);
            divz_q   <= op_is_div(op_sel) && (alu_b == '0);
`endif
          end else begin
            if (op_mthi) hi_q <= alu_a;
            if (op_mtlo) lo_q <= alu_a;
          end
        end
        ST_CALC: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + 1'b1;
        end
        ST_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
          dz_q   <= divz_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_mult = 1'b0, op_multu = 1'b0, op_div = 1'b0, op_divu = 1'b0;
  logic          op_mthi = 1'b0, op_mtlo = 1'b0;
  logic [W-1:0]  alu_a = '0, alu_b = '0;
  logic [W-1:0]  hi, lo;
  logic          busy, done, div_zero;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .op_mthi(op_mthi), .op_mtlo(op_mtlo),
    .alu_a(alu_a), .alu_b(alu_b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference: op 0=mult 1=multu 2=div 3=divu; returns {div_zero, hi, lo}
  function automatic logic [64:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      0: begin p = sa * sb; return {1'b0, p[63:0]}; end
      1: begin p = ua * ub; return {1'b0, p[63:0]}; end
      2: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = ua / ub; r = ua % ub;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Present a start for one edge, then scramble operands to prove capture
  task automatic drive_start(input int op, input logic [31:0] a, input logic [31:0] b);
    alu_a = a; alu_b = b;
    op_mult = (op == 0); op_multu = (op == 1); op_div = (op == 2); op_divu = (op == 3);
    @(posedge clk); #1;
    op_mult = 0; op_multu = 0; op_div = 0; op_divu = 0;
    alu_a = $urandom; alu_b = $urandom;
  endtask

  // Wait (bounded) for done; cyc = edges after the start edge, 0 on timeout
  task automatic wait_done(output int cyc, output logic b_first, output logic b_done);
    cyc = 0; b_first = busy; b_done = 1'bx;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; b_done = busy; break; end
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 0;
    #2;
    n_checks++;
    if ({hi, lo, busy, done, div_zero} !== '0)
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, required all 0", hi, lo, busy, done, div_zero);
    else n_pass++;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_directed();
    int ops[$];
    logic [31:0] as[$], bs[$];
    int cyc; logic bf, bd; logic [64:0] exp;
    ops = '{1, 0}; as = '{32'hFFFF_FFFF, 32'hFFFF_FFFD}; bs = '{32'hFFFF_FFFF, 32'd5};
`ifdef MULDIV_DIV_EN
    ops.push_back(2); as.push_back(32'hFFFF_FFF9); bs.push_back(32'd2);
    ops.push_back(3); as.push_back(32'd7);         bs.push_back(32'd0);
    ops.push_back(2); as.push_back(32'h8000_0000); bs.push_back(32'hFFFF_FFFF);
    ops.push_back(2); as.push_back(32'hFFFF_FFF9); bs.push_back(32'd0);
`endif
    foreach (ops[i]) begin
      @(negedge clk);
      drive_start(ops[i], as[i], bs[i]);
      wait_done(cyc, bf, bd);
      exp = model(ops[i], as[i], bs[i]);
      n_checks++;
      if ({div_zero, hi, lo} !== exp)
        $display("FAIL directed_%0d: dz/hi/lo=%b/%h/%h required %b/%h/%h", i, div_zero, hi, lo, exp[64], exp[63:32], exp[31:0]);
      else n_pass++;
      n_checks++;
      if (cyc !== W + 1 || bf !== 1'b1 || bd !== 1'b0)
        $display("FAIL directed_timing_%0d: done_after=%0d busy_first=%b busy_at_done=%b required %0d/1/0", i, cyc, bf, bd, W + 1);
      else n_pass++;
    end
    // Known literal result for 0xFFFFFFFF x 0xFFFFFFFF would be overwritten above; recheck spot value
    @(negedge clk);
    drive_start(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bf, bd);
    n_checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001)
      $display("FAIL multu_max_literal: hi=%h lo=%h required fffffffe/00000001", hi, lo);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_pulse_width: done=%b required 0", done);
    else n_pass++;
  endtask

  task automatic test_random();
    int cyc; logic bf, bd; logic [64:0] exp;
    int op; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
`ifdef MULDIV_DIV_EN
      op = $urandom_range(0, 3);
`else
      op = $urandom_range(0, 1);
`endif
      a = rnd_operand(); b = rnd_operand();
      drive_start(op, a, b);   // back-to-back: issued in the done cycle
      wait_done(cyc, bf, bd);
      exp = model(op, a, b);
      n_checks++;
      if ({div_zero, hi, lo} !== exp || cyc !== W + 1)
        $display("FAIL random_%0d op%0d a=%h b=%h: dz/hi/lo=%b/%h/%h cyc=%0d required %b/%h/%h cyc=%0d",
                 i, op, a, b, div_zero, hi, lo, cyc, exp[64], exp[63:32], exp[31:0], W + 1);
      else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    int cyc; logic bf, bd; logic [64:0] exp; logic [31:0] a, b;
    a = $urandom; b = $urandom;
    @(negedge clk);
    drive_start(1, a, b);
    repeat (3) @(posedge clk);
    #1;
    op_multu = 1; op_mthi = 1; alu_a = 32'h1234; alu_b = 32'h5;
    repeat (5) @(posedge clk);
    #1;
    op_multu = 0; op_mthi = 0;
    wait_done(cyc, bf, bd);
    exp = model(1, a, b);
    n_checks++;
    if ({hi, lo} !== exp[63:0] || cyc == 0)
      $display("FAIL busy_ignore: hi=%h lo=%h required %h/%h", hi, lo, exp[63:32], exp[31:0]);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== exp[63:32])
      $display("FAIL busy_ignore_after: busy=%b hi=%h required 0/%h", busy, hi, exp[63:32]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc; logic bf, bd; logic [64:0] exp; logic [31:0] a, b;
    logic seen_done;
    @(negedge clk);
    drive_start(0, 32'h0001_2345, 32'hFFFF_0003);
    repeat (9) @(posedge clk);    // now 10 edges after start: CALC cycle 10
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b required 0/0/0/0", hi, lo, busy, done);
    else n_pass++;
    seen_done = 0;
    repeat (3) begin @(posedge clk); #1; if (done) seen_done = 1; end
    rst_n = 1;
    a = $urandom; b = $urandom;
    drive_start(0, a, b);         // first edge after release
    wait_done(cyc, bf, bd);
    exp = model(0, a, b);
    n_checks++;
    if (seen_done || {hi, lo} !== exp[63:0] || cyc !== W + 1)
      $display("FAIL reset_restart: spurious_done=%b hi=%h lo=%h cyc=%0d required 0/%h/%h/%0d",
               seen_done, hi, lo, cyc, exp[63:32], exp[31:0], W + 1);
    else n_pass++;
  endtask

  task automatic test_moves();
    logic [31:0] h0, v, a, b; int cyc; logic bf, bd; logic [64:0] exp;
    @(negedge clk);
    h0 = hi;
    alu_a = 32'hA5A5_A5A5; op_mtlo = 1;
    @(posedge clk); #1; op_mtlo = 0;
    n_checks++;
    if (lo !== 32'hA5A5_A5A5 || hi !== h0 || busy !== 1'b0)
      $display("FAIL mtlo: lo=%h hi=%h busy=%b required a5a5a5a5/%h/0", lo, hi, busy, h0);
    else n_pass++;
    v = $urandom; alu_a = v; op_mthi = 1;
    @(posedge clk); #1; op_mthi = 0;
    n_checks++;
    if (hi !== v || lo !== 32'hA5A5_A5A5)
      $display("FAIL mthi: hi=%h lo=%h required %h/a5a5a5a5", hi, lo, v);
    else n_pass++;
    a = $urandom; b = $urandom;
    op_mthi = 1;
    drive_start(1, a, b);
    op_mthi = 0;
    wait_done(cyc, bf, bd);
    exp = model(1, a, b);
    n_checks++;
    if ({hi, lo} !== exp[63:0] || cyc !== W + 1)
      $display("FAIL start_beats_move: hi=%h lo=%h cyc=%0d required %h/%h/%0d", hi, lo, cyc, exp[63:32], exp[31:0], W + 1);
    else n_pass++;
  endtask

`ifndef MULDIV_DIV_EN
  task automatic test_no_div();
    logic [31:0] h0, l0; logic bad;
    @(negedge clk);
    h0 = hi; l0 = lo; bad = 0;
    for (int op = 2; op <= 3; op++) begin
      drive_start(op, $urandom, 32'd3);
      repeat (3) begin
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi !== h0 || lo !== l0) bad = 1;
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (bad) $display("FAIL no_div: busy=%b done=%b hi=%h lo=%h required 0/0/%h/%h", busy, done, hi, lo, h0, l0);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_moves();
`ifndef MULDIV_DIV_EN
    test_no_div();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
